div_unit: RTL
=============

Name: div_unit

Overview:
- Iterative 32-bit radix-2 divider in the EX stage of the 5-stage pipeline; executes DIV/DIVU.
- Raises a stall request that feeds the stall controller's `stallreq_for_ex` input, so the stall bus freezes PC, IF, ID and EX while the divide runs.
- Returns the {HI, LO} = {remainder, quotient} pair for the HI/LO write path.

Parameters:
- DATA_W, 32, operand width; quotient and remainder are each DATA_W bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- start_i  in  1  EX holds a divide instruction; held high until ready_o is seen.
- signed_i  in  1  1 = DIV (signed), 0 = DIVU (unsigned); sampled at start.
- annul_i  in  1  abandon the current divide (pipeline flush); highest priority after rst.
- opdata1_i  in  DATA_W  dividend; sampled at start.
- opdata2_i  in  DATA_W  divisor; sampled at start.
- result_o  out  2*DATA_W  {remainder, quotient}; valid only while ready_o=1.
- ready_o  out  1  result valid; one-cycle pulse, registered.
- stallreq_o  out  1  combinational: start_i & ~ready_o; drives stallreq_for_ex.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=FREE, counter=0, ready_o=0, result_o=0, internal dividend/divisor registers=0.
  - Reset aborts any in-flight divide with no result.
- FSM states: FREE, BY_ZERO, ON, END.
- FREE:
  - Stays in FREE while start_i=0 or annul_i=1.
  - On start_i=1 & annul_i=0:
    - if opdata2_i=0, go to BY_ZERO;
    - otherwise latch operands and go to ON with counter=0.
  - Signed mode latches absolute values |opdata1_i| and |opdata2_i|, plus the sign-fix flags:
    - neg_q = op1[31]^op2[31];
    - neg_r = op1[31].
- BY_ZERO: next cycle go to END with quotient=0 and remainder=0.
- ON:
  - One restoring step per cycle over a 2*DATA_W+1 partial-remainder register:
    - shift left 1;
    - subtract divisor from the upper half;
    - if no borrow, keep the difference and set quotient bit to 1; else keep the shifted value and set the bit to 0.
  - counter increments each cycle; after the step with counter=DATA_W-1, go to END.
  - ON therefore lasts exactly DATA_W cycles.
  - annul_i=1 in ON: go to FREE next edge; ready_o stays 0.
- END:
  - ready_o=1 and result_o holds the sign-corrected values:
    - quotient negated if signed_i & neg_q;
    - remainder negated if signed_i & neg_r.
  - Next edge always returns to FREE with ready_o=0 and result_o=0.
  - A still-high start_i in that FREE cycle begins a new divide.
- Latency, measured from the start edge:
  - normal divide: ready_o asserts DATA_W+1 cycles later (33 at default);
  - divide by zero: ready_o asserts 2 cycles later.
- stallreq_o is high on the start cycle through the cycle before END, and drops in the END cycle so EX advances.
- Arithmetic and edge cases:
  - 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0 (two's-complement wrap, no trap).
  - Operand changes after start are ignored.
- Simultaneous events:
  - rst beats annul_i;
  - annul_i beats start_i;
  - annul_i in BY_ZERO or END returns the FSM to FREE with ready_o=0.

Decomposition:
- Shared defines header: state encodings (DivFree, DivByZero, DivOn, DivEnd) and DATA_W default, next to the existing StallBus width.
- No sub-module needed. Optionally split the single subtract/compare step into div_step as a pure combinational helper.

Test Plan:
- Unsigned 100/7, start held → stallreq_o high for 33 cycles; ready_o pulse at cycle 33 with result_o={0x00000002, 0x0000000E}.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divisor 0 (any dividend) → ready_o at cycle 2, result_o=0, stallreq_o high for cycles 0-1 only.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- annul_i pulse at cycle 10 of a divide → FREE at cycle 11, ready_o never asserts. A new start at cycle 12 yields the correct result 33 cycles later.
- rst=0 at cycle 15 mid-divide → all outputs 0 next edge, FSM in FREE. Back-to-back starts (start held through END) → second result exactly 34 cycles after the first.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared types for the EX-stage divider: FSM state encodings and widths.
// Ports: none (package only).
package div_unit_pkg;

    localparam int STALL_W    = 6;
    localparam int DIV_DATA_W = 32;

    typedef enum logic [1:0] {
        DivFree,
        DivByZero,
        DivOn,
        DivEnd
    } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division step over the 2*DATA_W+1 partial remainder.
// Ports: rem_cur (in), divisor (in), rem_next (out); purely combinational.
module div_unit_step #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W:0]  rem_cur,
    input  logic [DATA_W-1:0]  divisor,
    output logic [2*DATA_W:0]  rem_next
);

    logic [2*DATA_W:0] shifted;
    logic [DATA_W+1:0] diff;
    logic              borrow;

    always_comb begin
        shifted = {rem_cur[2*DATA_W-1:0], 1'b0};
        diff    = {1'b0, shifted[2*DATA_W:DATA_W]} - {2'b0, divisor};
        // A set top bit means the shifted upper half already exceeds
        // any divisor, so the subtract cannot borrow.
        borrow  = ~rem_cur[2*DATA_W] & diff[DATA_W+1];
        if (borrow) begin
            rem_next = shifted;
        end else begin
            rem_next = {diff[DATA_W:0], shifted[DATA_W-1:1], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 DIV/DIVU unit for the EX stage with stall request.
// Ports: clk, rst (sync active-low), start_i, signed_i, annul_i,
//        opdata1_i, opdata2_i -> result_o {rem,quo}, ready_o, stallreq_o.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic                  annul_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_o
);

    div_state_e          state;
    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W:0]   rem_q;
    logic [DATA_W-1:0]   divisor_q;
    logic                neg_q;
    logic                neg_r;

    logic [2*DATA_W:0]   rem_next;
    logic [DATA_W-1:0]   op1_abs;
    logic [DATA_W-1:0]   op2_abs;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   rmd;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rmd_fix;
    logic                op1_neg;
    logic                op2_neg;
    logic                last_step;

    assign stallreq_o = start_i & ~ready_o;

    assign op1_neg = signed_i & opdata1_i[DATA_W-1];
    assign op2_neg = signed_i & opdata2_i[DATA_W-1];
    assign op1_abs = op1_neg ? -opdata1_i : opdata1_i;
    assign op2_abs = op2_neg ? -opdata2_i : opdata2_i;

    div_unit_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .rem_cur  (rem_q),
        .divisor  (divisor_q),
        .rem_next (rem_next)
    );

    // The last step's output is corrected and registered directly so
    // the result is already valid in the END cycle.
    assign quo       = rem_next[DATA_W-1:0];
    assign rmd       = rem_next[2*DATA_W-1:DATA_W];
    assign quo_fix   = neg_q ? -quo : quo;
    assign rmd_fix   = neg_r ? -rmd : rmd;
    assign last_step = (cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= DivFree;
            cnt       <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            ready_o   <= 1'b0;
            result_o  <= '0;
        end else if (annul_i) begin
            state    <= DivFree;
            cnt      <= '0;
            ready_o  <= 1'b0;
            result_o <= '0;
        end else begin
            unique case (state)
                DivFree: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (start_i) begin
                        if (opdata2_i == '0) begin
                            state <= DivByZero;
                        end else begin
                            state     <= DivOn;
                            cnt       <= '0;
                            rem_q     <= {{(DATA_W+1){1'b0}}, op1_abs};
                            divisor_q <= op2_abs;
                            neg_q     <= op1_neg ^ op2_neg;
                            neg_r     <= op1_neg;
                        end
                    end
                end
                DivByZero: begin
                    state    <= DivEnd;
                    ready_o  <= 1'b1;
                    result_o <= '0;
                end
                DivOn: begin
                    rem_q <= rem_next;
                    cnt   <= cnt + 1'b1;
                    if (last_step) begin
                        state    <= DivEnd;
                        ready_o  <= 1'b1;
                        result_o <= {rmd_fix, quo_fix};
                    end
                end
                DivEnd: begin
                    state    <= DivFree;
                    ready_o  <= 1'b0;
                    result_o <= '0;
                end
                default: begin
                    state <= DivFree;
                end
            endcase
        end
    end

endmodule
